window3x3_pad1: RTL and testbench

//  Consumes the raster pixel stream produced by the 2x2/s2 maxpool stage (one DATA_WIDTH word per beat,
//  row-major, IMG_SIZE x IMG_SIZE) and emits one zero-padded 3x3 window per input pixel (stride 1,
//  pad 1, "same") for the following 3x3 conv stage. Windows come out in raster order of their centre

---
 rtl/window3x3_pad1.sv | 140 ++++++++++++++
 tb/tb_window3x3_pad1.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/window3x3_pad1.sv
// Zero-padded 3x3 sliding-window generator (stride 1, "same") over a raster pixel stream.
// One window per input pixel, in raster order of the centre; a flush phase drains the last N+1 centres.
module window3x3_pad1 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_SIZE   = 208
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [9*DATA_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    frame_end_out,
  output logic                    overflow
);

  localparam int unsigned N        = IMG_SIZE;
  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned LINE_LEN = 2 * N + 2;
  localparam int unsigned CNT_W    = $clog2(N * N + 1);
  localparam int unsigned POS_W    = $clog2(N);

  typedef enum logic {ST_STREAM = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LINE_LEN*DW-1:0] r_line;
  logic [CNT_W-1:0]       r_in_cnt;
  logic [POS_W-1:0]       r_crow;
  logic [POS_W-1:0]       r_ccol;

  logic                   w_accept;
  logic                   w_shift;
  logic                   w_emit;
  logic [DW-1:0]          w_new;
  logic                   w_last_ctr;
  logic                   w_top;
  logic                   w_bot;
  logic                   w_left;
  logic                   w_right;
  logic [9*DW-1:0]        w_win;

  assign w_accept   = valid_in & ready_out;
  assign w_top      = (r_crow == POS_W'(0));
  assign w_bot      = (r_crow == POS_W'(N - 1));
  assign w_left     = (r_ccol == POS_W'(0));
  assign w_right    = (r_ccol == POS_W'(N - 1));
  assign w_last_ctr = w_bot & w_right;

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= ST_STREAM;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STREAM: if (w_accept && (r_in_cnt == CNT_W'(N * N - 1))) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (w_last_ctr) w_state_nxt = ST_STREAM;
      default:   w_state_nxt = ST_STREAM;
    endcase
  end

  // Per-state shift/emit controls; flush shifts zeros into the line
  always_comb begin
    w_shift = 1'b0;
    w_emit  = 1'b0;
    w_new   = '0;
    case (r_state)
      ST_STREAM: begin
        w_shift = w_accept;
        w_emit  = w_accept && (r_in_cnt >= CNT_W'(N + 1));
        w_new   = data_in;
      end
      ST_FLUSH: begin
        w_shift = 1'b1;
        w_emit  = 1'b1;
      end
      default: ;
    endcase
  end

  // Window taps are read from the post-shift line; tap t = word shifted in t shifts ago
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    localparam int unsigned ROW = gi / 3;
    localparam int unsigned COL = gi % 3;
    localparam int unsigned TAP = (2 - ROW) * N + (2 - COL);
    logic [DW-1:0] w_raw;
    logic          w_mask;
    if (TAP == 0) begin : g_new
      assign w_raw = w_new;
    end else begin : g_line
      assign w_raw = r_line[(TAP-1)*DW +: DW];
    end
    assign w_mask = ((ROW == 0) && w_top)  || ((ROW == 2) && w_bot) ||
                    ((COL == 0) && w_left) || ((COL == 2) && w_right);
    assign w_win[gi*DW +: DW] = w_mask ? '0 : w_raw;
  end

  always_ff @(posedge Clk) begin
    if (w_shift) r_line <= {r_line[(LINE_LEN-1)*DW-1:0], w_new};
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ready_out     <= 1'b0;
      valid_out     <= 1'b0;
      data_out      <= '0;
      frame_end_out <= 1'b0;
      overflow      <= 1'b0;
      r_in_cnt      <= '0;
      r_crow        <= '0;
      r_ccol        <= '0;
    end else begin
      ready_out     <= (w_state_nxt == ST_STREAM);
      valid_out     <= w_emit;
      frame_end_out <= w_emit && w_last_ctr;
      if (w_emit) data_out <= w_win;
      if (valid_in && !ready_out) overflow <= 1'b1;
      if (w_accept) r_in_cnt <= r_in_cnt + CNT_W'(1);
      // Centre position advances per emitted window; the final centre closes the frame
      if (w_emit) begin
        if (w_last_ctr) begin
          r_crow   <= '0;
          r_ccol   <= '0;
          r_in_cnt <= '0;
        end else if (w_right) begin
          r_ccol <= '0;
          r_crow <= r_crow + POS_W'(1);
        end else begin
          r_ccol <= r_ccol + POS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window3x3_pad1.sv
// Self-checking bench for window3x3_pad1 at IMG_SIZE=4: directed frames with random gaps,
// compared against a neighbourhood model computed directly from frame coordinates.
module tb_window3x3_pad1;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned WW = 9 * DW;

  logic          Clk;
  logic          Rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic [WW-1:0] data_out;
  logic          valid_out;
  logic          frame_end_out;
  logic          overflow;

  window3x3_pad1 #(.DATA_WIDTH(DW), .IMG_SIZE(N)) dut (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .frame_end_out(frame_end_out), .overflow(overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int            checks;
  int            errors;
  logic [WW-1:0] exp_q[$];
  logic          fe_q[$];
  logic          exp_ovf;
  int            acc;
  int            first_acc;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference window: 3x3 neighbourhood of (r,c), zero outside the frame; pixel = base + raster index + 1
  function automatic logic [WW-1:0] ref_win(input int base, input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        int rr;
        int cc;
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr >= 0 && rr < int'(N) && cc >= 0 && cc < int'(N))
          w[(3*dr+dc)*DW +: DW] = DW'(base + rr * int'(N) + cc + 1);
      end
    end
    return w;
  endfunction

  task automatic push_frame(input int base);
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        exp_q.push_back(ref_win(base, r, c));
        fe_q.push_back((r == int'(N) - 1) && (c == int'(N) - 1));
      end
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d);
    logic          rdy;
    logic [WW-1:0] w;
    logic          fe;
    rdy      = ready_out;
    valid_in = v;
    data_in  = d;
    @(posedge Clk);
    #1;
    if (!Rst) begin
      chk("rst_valid", WW'(valid_out), WW'(0));
      chk("rst_data", data_out, WW'(0));
      chk("rst_ready", WW'(ready_out), WW'(0));
      chk("rst_overflow", WW'(overflow), WW'(0));
    end else begin
      if (v && rdy) acc++;
      if (v && !rdy) exp_ovf = 1'b1;
      chk("overflow", WW'(overflow), WW'(exp_ovf));
      if (valid_out) begin
        if (first_acc < 0) first_acc = acc;
        if (exp_q.size() == 0) begin
          chk("extra_window", WW'(valid_out), WW'(0));
        end else begin
          w  = exp_q.pop_front();
          fe = fe_q.pop_front();
          chk("window", data_out, w);
          chk("frame_end", WW'(frame_end_out), WW'(fe));
        end
      end
    end
  endtask

  task automatic feed(input int base, input bit gaps, input int nbeats);
    int   k;
    int   guard;
    logic v;
    logic rdy;
    push_frame(base);
    k = 0;
    guard = 0;
    while (k < nbeats && guard < 2000) begin
      v   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy = ready_out;
      cycle(v, DW'(base + k + 1));
      if (v && rdy) k++;
      guard++;
    end
    chk("feed_done", WW'(k), WW'(nbeats));
  endtask

  task automatic drain(input bit flush_drive);
    int low;
    int g;
    low = ready_out ? 0 : 1;
    g = 0;
    while ((exp_q.size() > 0 || !ready_out) && g < 50) begin
      cycle(flush_drive && !ready_out, 32'hDEAD_BEEF);
      if (!ready_out) low++;
      g++;
    end
    chk("ready_gap", WW'(low), WW'(N + 1));
    chk("drained", WW'(exp_q.size()), WW'(0));
  endtask

  task automatic do_reset(input int n, input logic v);
    Rst = 1'b0;
    for (int i = 0; i < n; i++) cycle(v, 32'h1234_5678);
    Rst = 1'b1;
    exp_q.delete();
    fe_q.delete();
    exp_ovf = 1'b0;
    cycle(1'b0, '0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_ovf   = 1'b0;
    acc       = 0;
    first_acc = -1;
    Rst       = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;

    // Reset held with valid_in asserted
    do_reset(3, 1'b1);
    chk("ready_after_release", WW'(ready_out), WW'(1));

    // Contiguous frame: fill latency, window contents, flush gap
    acc = 0;
    first_acc = -1;
    feed(0, 1'b0, int'(N * N));
    chk("fill_latency", WW'(first_acc), WW'(N + 2));
    drain(1'b0);

    // Same frame with random input gaps
    feed(0, 1'b1, int'(N * N));
    drain(1'b0);

    // valid_in during flush raises sticky overflow, windows unchanged
    feed(0, 1'b0, int'(N * N));
    drain(1'b1);
    chk("ovf_set", WW'(overflow), WW'(1));

    // Back-to-back frames with distinct values
    feed(100, 1'b0, int'(N * N));
    drain(1'b0);
    feed(200, 1'b1, int'(N * N));
    drain(1'b0);
    chk("ovf_sticky", WW'(overflow), WW'(1));

    // Mid-frame reset discards the partial frame
    feed(0, 1'b0, 9);
    do_reset(2, 1'b0);
    chk("ovf_cleared", WW'(overflow), WW'(0));
    feed(300, 1'b1, int'(N * N));
    drain(1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b0, '0);
    chk("no_leftover", WW'(exp_q.size()), WW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
